grain_ctrl: RTL

Sequencer for the Grain-style keystream datapath: an 80-bit LFSR plus a 24-bit NFSR with filter output `f`. The block captures a 104-bit seed, parallel-loads it into the registers, and runs a fixed number of initialization rounds with `f` fed back into both serial inputs. It then clocks the registers in keystream mode and packs `f` bits into OUT_W-bit words. Words leave on a valid/ready handshake, and the registers stall under backpressure. The block sits between the system bus side and the cipher datapath and holds no cipher state itself.

---
 rtl/grain_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/grain_ctrl.sv
// Sequencer for a Grain-style keystream datapath: seed load, init rounds, then
// keystream packing into OUT_W-bit words on a valid/ready handshake.
module grain_ctrl #(
   parameter int INIT_ROUNDS = 160,
   parameter int OUT_W       = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic [103:0]     i_seed_in,
   input  logic             i_f,
   output logic             o_par_load,
   output logic [103:0]     o_par_in,
   output logic             o_shift_en,
   output logic             o_init_fb,
   output logic [OUT_W-1:0] o_ks_data,
   output logic             o_ks_valid,
   input  logic             i_ks_ready,
   output logic             o_busy,
   output logic             o_init_done
);
   localparam int RW = $clog2(INIT_ROUNDS + 1);
   localparam int BW = $clog2(OUT_W);
   localparam logic [RW-1:0] LAST_RND = RW'(INIT_ROUNDS - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(OUT_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_INIT, S_RUN} state_t;

   state_t           r_state, w_next;
   logic [RW-1:0]    r_round_cnt;
   logic [BW-1:0]    r_bit_cnt;
   logic [OUT_W-2:0] r_acc;
   logic [103:0]     r_par_in;
   logic [OUT_W-1:0] r_ks_data;
   logic             r_ks_valid;

   logic w_last_bit, w_stall, w_collect;

   // Stall only on the last bit of a word, so a pending word never loses a bit.
   assign w_last_bit = (r_bit_cnt == LAST_BIT);
   assign w_stall    = r_ks_valid & ~i_ks_ready & w_last_bit;
   assign w_collect  = (r_state == S_RUN) & ~w_stall;

   assign o_par_load  = (r_state == S_LOAD);
   assign o_init_fb   = (r_state == S_INIT);
   assign o_shift_en  = (r_state == S_INIT) | w_collect;
   assign o_busy      = (r_state != S_IDLE);
   assign o_init_done = (r_state == S_RUN);
   assign o_par_in    = r_par_in;
   assign o_ks_data   = r_ks_data;
   assign o_ks_valid  = r_ks_valid;

   always_comb begin
      w_next = r_state;
      if (i_stop) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: if (i_start) w_next = S_LOAD;
            S_LOAD: w_next = S_INIT;
            S_INIT: if (r_round_cnt == LAST_RND) w_next = S_RUN;
            default: w_next = r_state;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_round_cnt <= '0;
         r_bit_cnt   <= '0;
         r_acc       <= '0;
         r_par_in    <= '0;
         r_ks_data   <= '0;
         r_ks_valid  <= 1'b0;
      end else if (i_stop) begin
         // Partial word is dropped by rewinding bit_cnt; ks_data keeps its value.
         r_round_cnt <= '0;
         r_bit_cnt   <= '0;
         r_ks_valid  <= 1'b0;
      end else begin
         if (r_state == S_IDLE && i_start) r_par_in <= i_seed_in;

         if (r_state == S_LOAD)      r_round_cnt <= '0;
         else if (r_state == S_INIT) r_round_cnt <= r_round_cnt + 1'b1;

         if (w_collect) begin
            for (int i = 0; i < OUT_W - 1; i++)
               if (r_bit_cnt == BW'(i)) r_acc[i] <= i_f;
            r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
         end

         if (w_collect && w_last_bit) begin
            r_ks_data  <= {i_f, r_acc};
            r_ks_valid <= 1'b1;
         end else if (r_ks_valid && i_ks_ready) begin
            r_ks_valid <= 1'b0;
         end
      end
   end
endmodule
